// File: rtl/div_axis_pkg.sv
// rtl/div_axis_pkg.sv - shared widths, FSM states and sign helpers for div_axis
package div_axis_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic en);
        return en ? (~v + DIV_W'(1)) : v;
    endfunction

    // Absolute value only when the operand is treated as two's complement.
    function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[DIV_W-1]);
    endfunction

endpackage

// File: rtl/div_axis_if.sv
// rtl/div_axis_if.sv - operand/result stream bundle between DIV/MOD sequencer and divider
interface div_axis_if;

    logic                               s_axis_dividend_tvalid;
    logic                               s_axis_dividend_tready;
    logic [div_axis_pkg::DIV_W-1:0]     s_axis_dividend_tdata;
    logic                               s_axis_divisor_tvalid;
    logic                               s_axis_divisor_tready;
    logic [div_axis_pkg::DIV_W-1:0]     s_axis_divisor_tdata;
    logic                               m_axis_dout_tvalid;
    logic [2*div_axis_pkg::DIV_W-1:0]   m_axis_dout_tdata;

    modport slave (
        input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
        input  s_axis_divisor_tvalid,  s_axis_divisor_tdata,
        output s_axis_dividend_tready, s_axis_divisor_tready,
        output m_axis_dout_tvalid,     m_axis_dout_tdata
    );

    modport master (
        output s_axis_dividend_tvalid, s_axis_dividend_tdata,
        output s_axis_divisor_tvalid,  s_axis_divisor_tdata,
        input  s_axis_dividend_tready, s_axis_divisor_tready,
        input  m_axis_dout_tvalid,     m_axis_dout_tdata
    );

endinterface

// File: rtl/div_axis_step.sv
// rtl/div_axis_step.sv - one radix-2 restoring division iteration (combinational)
module div_axis_step
    import div_axis_pkg::*;
(
    input  logic [DIV_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DIV_W-1:0] dmag_i,
    output logic [DIV_W-1:0] rem_o,
    output logic             q_o
);

    logic [DIV_W:0] trial;

    // Trial subtract; a non-negative result means the divisor fits this step.
    always_comb begin
        trial = {rem_i, bit_i} - {1'b0, dmag_i};
        q_o   = ~trial[DIV_W];
        rem_o = q_o ? trial[DIV_W-1:0] : {rem_i[DIV_W-2:0], bit_i};
    end

endmodule

// File: rtl/div_axis.sv
// rtl/div_axis.sv - 32-bit multi-cycle restoring divider with stream operands and result
module div_axis
    import div_axis_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic      aclk,
    input  logic      aresetn,
    div_axis_if.slave axis
);

    div_state_e         state_q, state_d;
    logic               have_a_q, have_b_q;
    logic [DIV_W-1:0]   a_q, b_q;
    logic [DIV_W-1:0]   rem_q, div_q;
    logic [CNT_W-1:0]   count_q;
    logic               neg_q_q, neg_r_q;
    logic [2*DIV_W-1:0] dout_q;

    logic               tready_a, tready_b, hs_a, hs_b, start;
    logic [DIV_W-1:0]   a_val, b_val, b_mag, step_rem, quot_fin;
    logic               step_q, sa, sb;
    logic [2*DIV_W-1:0] result;

    // Operand channels accept only while idle and not already holding a value;
    // a same-cycle handshake feeds the operand straight into the CALC setup.
    assign tready_a = (state_q == DIV_IDLE) & ~have_a_q;
    assign tready_b = (state_q == DIV_IDLE) & ~have_b_q;
    assign hs_a     = axis.s_axis_dividend_tvalid & tready_a;
    assign hs_b     = axis.s_axis_divisor_tvalid & tready_b;
    assign a_val    = hs_a ? axis.s_axis_dividend_tdata : a_q;
    assign b_val    = hs_b ? axis.s_axis_divisor_tdata : b_q;
    assign start    = (have_a_q | hs_a) & (have_b_q | hs_b);
    assign sa       = SIGNED & a_val[DIV_W-1];
    assign sb       = SIGNED & b_val[DIV_W-1];
    assign b_mag    = magnitude(b_q, SIGNED);

    div_axis_step u_step (
        .rem_i  (rem_q),
        .bit_i  (div_q[DIV_W-1]),
        .dmag_i (b_mag),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    // Final result from the last iteration; a zero divisor bypasses sign fixup.
    always_comb begin
        quot_fin = {div_q[DIV_W-2:0], step_q};
        if (b_q == '0) begin
            result = {{DIV_W{1'b1}}, a_q};
        end else begin
            result = {cond_neg(quot_fin, neg_q_q), cond_neg(step_rem, neg_r_q)};
        end
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= DIV_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state: wait for both operands, iterate 32 times, present one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start) state_d = DIV_CALC;
            DIV_CALC: if (count_q == CNT_LAST) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Operand capture, shift/subtract datapath and result register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            have_a_q <= 1'b0;
            have_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            count_q  <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            if (hs_a) begin
                a_q      <= axis.s_axis_dividend_tdata;
                have_a_q <= 1'b1;
            end
            if (hs_b) begin
                b_q      <= axis.s_axis_divisor_tdata;
                have_b_q <= 1'b1;
            end
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        have_a_q <= 1'b0;
                        have_b_q <= 1'b0;
                        count_q  <= '0;
                        rem_q    <= '0;
                        div_q    <= magnitude(a_val, SIGNED);
                        neg_q_q  <= sa ^ sb;
                        neg_r_q  <= sa;
                    end
                end
                DIV_CALC: begin
                    rem_q   <= step_rem;
                    div_q   <= quot_fin;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_LAST) dout_q <= result;
                end
                default: ;
            endcase
        end
    end

    assign axis.s_axis_dividend_tready = tready_a;
    assign axis.s_axis_divisor_tready  = tready_b;
    assign axis.m_axis_dout_tvalid     = (state_q == DIV_DONE);
    assign axis.m_axis_dout_tdata      = dout_q;

endmodule
